// File: rtl/act_weight_dispatcher.sv
// Activation/weight dispatcher: buffers one iteration of activation groups and replays them once per weight.
// Optional macro DISPATCHER_REP_SKIP_EN: emit one beat per repetition leader instead of one per position.
module act_weight_dispatcher #(
  parameter int DATA_WIDTH             = 8,
  parameter int GROUP_SIZE             = 4,
  parameter int REP_INFO               = GROUP_SIZE * GROUP_SIZE,
  parameter int MAX_READS              = 16,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   configure,
  input  logic [LOG_MAX_ITERS-1:0]               num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]      num_reads_per_iter,
  input  logic [DATA_WIDTH*GROUP_SIZE+REP_INFO-1:0] act_data_in,
  input  logic                                   act_valid_in,
  output logic                                   act_avail_out,
  input  logic [DATA_WIDTH-1:0]                  weight_data_in,
  input  logic                                   weight_valid_in,
  output logic                                   weight_avail_out,
  output logic [2*DATA_WIDTH+GROUP_SIZE-1:0]     data_out,
  output logic                                   valid_out,
  input  logic                                   avail_in,
  output logic                                   done_out
);
  // state  | meaning
  // IDLE   | waiting for a configure with nonzero parameters
  // LOAD   | accepting the iteration's activation groups into the buffer
  // WAIT_W | waiting for the weight of the next iteration
  // SEND   | replaying the buffer, one beat per emitting position
  // DONE   | letting the final beat drain, then pulsing done_out

  localparam int ACT_W = DATA_WIDTH * GROUP_SIZE + REP_INFO;
  localparam int VAL_W = DATA_WIDTH * GROUP_SIZE;
  localparam int PTR_W = (MAX_READS > 1) ? $clog2(MAX_READS) : 1;
  localparam int POS_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_W, S_SEND, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ACT_W-1:0]         act_buf [MAX_READS];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, last_idx;
  logic [POS_W-1:0]         pos_ptr, lead_pos;
  logic [LOG_MAX_ITERS-1:0] iter_cnt, iters_q, iter_inc;
  logic [DATA_WIDTH-1:0]    weight_q, beat_w, beat_val;
  logic [ACT_W-1:0]         cur_grp;
  logic [GROUP_SIZE-1:0]    leaders, remaining, rest, beat_mask;
  logic lead_found, out_free, start_ok, act_acc, w_acc, step_en;
  logic grp_adv, beat_load, last_grp, done_d;

  assign cur_grp = act_buf[rd_ptr];

`ifndef DISPATCHER_REP_SKIP_EN
  logic [REP_INFO-1:0] unused_rep;
  assign unused_rep = cur_grp[ACT_W-1 -: REP_INFO];
`endif

  // Find the next emitting position at or after pos_ptr in the current group.
  always_comb begin
    leaders   = '0;
    remaining = '0;
    for (int j = 0; j < GROUP_SIZE; j++) begin
`ifdef DISPATCHER_REP_SKIP_EN
      leaders[j] = |cur_grp[VAL_W + j*GROUP_SIZE +: GROUP_SIZE];
`else
      leaders[j] = 1'b1;
`endif
      remaining[j] = leaders[j] && (POS_W'(j) >= pos_ptr);
    end
    lead_found = 1'b0;
    lead_pos   = '0;
    for (int j = GROUP_SIZE - 1; j >= 0; j--) begin
      if (remaining[j]) begin
        lead_found = 1'b1;
        lead_pos   = POS_W'(j);
      end
    end
    rest = remaining;
    if (lead_found) rest[lead_pos] = 1'b0;
    beat_val = cur_grp[lead_pos*DATA_WIDTH +: DATA_WIDTH];
`ifdef DISPATCHER_REP_SKIP_EN
    beat_mask = cur_grp[VAL_W + lead_pos*GROUP_SIZE +: GROUP_SIZE];
`else
    beat_mask = '0;
    beat_mask[lead_pos] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    act_avail_out    = (state_q == S_LOAD);
    weight_avail_out = (state_q == S_WAIT_W);
    act_acc          = act_avail_out && act_valid_in;
    w_acc            = weight_avail_out && weight_valid_in;
    out_free         = !valid_out || avail_in;
    start_ok         = (num_iters != '0) && (num_reads_per_iter != '0);
    last_grp         = (rd_ptr == last_idx);
    iter_inc         = iter_cnt + 1'b1;
    beat_w           = (state_q == S_WAIT_W) ? weight_data_in : weight_q;
    step_en          = out_free && ((state_q == S_SEND) || w_acc);
    beat_load        = 1'b0;
    grp_adv          = 1'b0;
    done_d           = 1'b0;
    case (state_q)
      S_LOAD:   if (act_acc && (wr_ptr == last_idx)) state_d = S_WAIT_W;
      S_WAIT_W: if (w_acc) state_d = S_SEND;
      S_DONE: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    // The first beat is scanned in the acceptance cycle so it appears right after the weight edge.
    if (step_en) begin
      beat_load = lead_found;
      grp_adv   = !lead_found || (rest == '0);
      if (grp_adv && last_grp) state_d = (iter_inc >= iters_q) ? S_DONE : S_WAIT_W;
    end
    if (configure) begin
      state_d   = start_ok ? S_LOAD : S_IDLE;
      beat_load = 1'b0;
      grp_adv   = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      done_out  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pos_ptr   <= '0;
      iter_cnt  <= '0;
      iters_q   <= '0;
      last_idx  <= '0;
      weight_q  <= '0;
    end else begin
      done_out <= done_d;
      if (configure) begin
        valid_out <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        pos_ptr   <= '0;
        iter_cnt  <= '0;
        iters_q   <= num_iters;
        last_idx  <= (num_reads_per_iter > LOG_MAX_READS_PER_ITER'(MAX_READS))
                     ? PTR_W'(MAX_READS - 1)
                     : PTR_W'(num_reads_per_iter - 1'b1);
      end else begin
        if (valid_out && avail_in) valid_out <= 1'b0;
        if (act_acc) wr_ptr <= (wr_ptr == last_idx) ? '0 : wr_ptr + 1'b1;
        if (w_acc) begin
          weight_q <= weight_data_in;
          rd_ptr   <= '0;
          pos_ptr  <= '0;
        end
        if (beat_load) begin
          valid_out <= 1'b1;
          data_out  <= {beat_mask, beat_w, beat_val};
          if (!grp_adv) pos_ptr <= lead_pos + 1'b1;
        end
        if (grp_adv) begin
          pos_ptr <= '0;
          if (last_grp) begin
            rd_ptr   <= '0;
            iter_cnt <= iter_inc;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && act_acc && !configure) act_buf[wr_ptr] <= act_data_in;
  end

endmodule
